mul_unit: RTL and testbench
===========================

MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 SHALL have parameter RADIX_BITS, default 2: multiplier bits consumed per iteration; legal values 1, 2, 4.
REQ-002 SHALL have parameter EARLY_TERM, default 1: 1 = stop iterating once the remaining multiplier is zero.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  request; sampled only in IDLE.
REQ-006 SHALL have port accumulate  in  1  1 = MLA (add Rn), 0 = MUL.
REQ-007 SHALL have port Rm  in  32  multiplicand from register file.
REQ-008 SHALL have port Rs  in  32  multiplier from register file.
REQ-009 SHALL have port Rn  in  32  accumulate operand from register file.
REQ-010 SHALL have port rd_addr  in  4  destination register address.
REQ-011 SHALL have port busy  out  1  high in CALC and DONE.
REQ-012 SHALL have port done  out  1  one-cycle completion pulse.
REQ-013 SHALL have port write_en  out  1  register-file write enable; one-cycle pulse.
REQ-014 SHALL have port result  out  32  product (low 32 bits), registered.
REQ-015 SHALL have port result_addr  out  4  latched rd_addr.
REQ-016 SHALL have port flag_N  out  1  result[31], valid while done is high.
REQ-017 SHALL have port flag_Z  out  1  result == 0, valid while done is high.
REQ-018 SHALL have port illegal  out  1  one-cycle pulse: rd_addr was 15.

Function
REQ-019 SHALL implement FSM states IDLE, CALC and DONE.
REQ-020 IDLE with start=1 SHALL latch mcand=Rm, mplier=Rs, acc=(accumulate ? Rn : 0), addr=rd_addr, and clear the iteration counter.
REQ-021 On that start edge the FSM SHALL go to DONE if EARLY_TERM=1 and Rs==0; otherwise it SHALL go to CALC.
REQ-022 Each CALC cycle SHALL do: acc += mcand * mplier[RADIX_BITS-1:0] mod 2^32; mcand <<= RADIX_BITS; mplier >>= RADIX_BITS (logical); counter += 1.
REQ-023 CALC SHALL exit to DONE after the iteration that makes counter == 32/RADIX_BITS, or, when EARLY_TERM=1, after the iteration whose shifted mplier == 0.
REQ-024 Latency: with N iterations, done SHALL be high in the cycle N+1 after the start edge (N=0 to 32/RADIX_BITS).
REQ-025 DONE SHALL last exactly one cycle: result=acc, done=1, and write_en=1 unless addr==15; the next state is always IDLE.
REQ-026 If addr==15, the DONE cycle SHALL drive write_en=0 and illegal=1 (r15 is owned by PC update); result, flag_N and flag_Z are still driven.
REQ-027 start SHALL be ignored in CALC and DONE, with no queuing; the first start accepted is in the IDLE cycle after DONE.
REQ-028 Operands SHALL be treated as unsigned; the low 32 bits equal the signed product, and carry-out is discarded.
REQ-029 result and result_addr SHALL hold their values between completions; flag_N and flag_Z are combinational from result.
REQ-030 Input changes on Rm, Rs, Rn, accumulate and rd_addr after the start edge SHALL NOT affect the operation in flight.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE and busy=done=write_en=illegal=0, result=0, result_addr=0, and clear all internal registers.
REQ-032 Reset during CALC or DONE SHALL abort the operation with no write_en pulse; after rst_n deassertion, the first start is accepted normally.

Verification
REQ-033 MUL, Rm=7, Rs=6, rd=3, defaults -> N=2; done/write_en high in cycle 3 after start; result=42, result_addr=3, N=0, Z=0.
REQ-034 MUL, Rm=Rs=0xFFFFFFFF -> N=16; done in cycle 17; result=0x00000001; busy high for 17 cycles.
REQ-035 MLA, Rm=3, Rs=4, Rn=0xFFFFFFF4 -> result=0, flag_Z=1; then MLA, Rs=0, Rn=5 -> done in the next cycle, result=5.
REQ-036 rd_addr=15, Rm=2, Rs=2 -> done=1, illegal=1, write_en=0, result=4.
REQ-037 start pulsed repeatedly during CALC with different operands -> ignored; the original result is delivered; a start in the following IDLE cycle is accepted.
REQ-038 rst_n low for 1 cycle mid-CALC -> busy falls asynchronously, no done or write_en; the next MUL (5x5) returns 25.

Source files
------------

// File: rtl/mul_unit.sv
// Iterative radix-2^RADIX_BITS shift-add multiplier (MUL/MLA) with register-file write-back.
// Latency: N+1 cycles from the start edge to the done pulse, N = iterations (0 .. 32/RADIX_BITS).
// Backpressure: none; start is only sampled in IDLE, requests while busy are dropped (no queuing).
module mul_unit #(
    parameter int RADIX_BITS = 2,
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        accumulate,
    input  logic [31:0] Rm,
    input  logic [31:0] Rs,
    input  logic [31:0] Rn,
    input  logic [3:0]  rd_addr,
    output logic        busy,
    output logic        done,
    output logic        write_en,
    output logic [31:0] result,
    output logic [3:0]  result_addr,
    output logic        flag_N,
    output logic        flag_Z,
    output logic        illegal
);

    localparam int          ITERS    = 32 / RADIX_BITS;
    localparam logic [5:0]  LAST_CNT = 6'(ITERS);
    localparam logic [3:0]  PC_ADDR  = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [31:0]            mcand;
    logic [31:0]            mplier;
    logic [31:0]            acc;
    logic [3:0]             addr;
    logic [5:0]             cnt;

    logic [RADIX_BITS-1:0]  digit;
    logic [31:0]            partial;
    logic [31:0]            acc_nxt;
    logic [31:0]            mplier_nxt;
    logic [5:0]             cnt_nxt;
    logic                   last_iter;

    // One iteration: shift-add of the multiplicand for each set bit of the low multiplier digit.
    always_comb begin
        digit   = mplier[RADIX_BITS-1:0];
        partial = 32'd0;
        for (int b = 0; b < RADIX_BITS; b++) begin
            if (digit[b]) begin
                partial = partial + (mcand << b);
            end
        end
        acc_nxt    = acc + partial;
        mplier_nxt = mplier >> RADIX_BITS;
        cnt_nxt    = cnt + 6'd1;
        // Stop after the full digit count, or early once no multiplier bits remain.
        last_iter  = (cnt_nxt == LAST_CNT) || (EARLY_TERM && (mplier_nxt == 32'd0));
    end

    // Control FSM and datapath; completion outputs are registered on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mcand       <= 32'd0;
            mplier      <= 32'd0;
            acc         <= 32'd0;
            addr        <= 4'd0;
            cnt         <= 6'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            write_en    <= 1'b0;
            illegal     <= 1'b0;
            result      <= 32'd0;
            result_addr <= 4'd0;
        end else begin
            done     <= 1'b0;
            write_en <= 1'b0;
            illegal  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= Rm;
                        mplier <= Rs;
                        acc    <= accumulate ? Rn : 32'd0;
                        addr   <= rd_addr;
                        cnt    <= 6'd0;
                        busy   <= 1'b1;
                        if (EARLY_TERM && (Rs == 32'd0)) begin
                            // Nothing to multiply: the product is just the accumulate operand.
                            state       <= DONE;
                            result      <= accumulate ? Rn : 32'd0;
                            result_addr <= rd_addr;
                            done        <= 1'b1;
                            write_en    <= (rd_addr != PC_ADDR);
                            illegal     <= (rd_addr == PC_ADDR);
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << RADIX_BITS;
                    mplier <= mplier_nxt;
                    cnt    <= cnt_nxt;
                    if (last_iter) begin
                        state       <= DONE;
                        result      <= acc_nxt;
                        result_addr <= addr;
                        done        <= 1'b1;
                        // r15 belongs to PC update: never write it, flag it instead.
                        write_en    <= (addr != PC_ADDR);
                        illegal     <= (addr == PC_ADDR);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Status flags follow the held result.
    assign flag_N = result[31];
    assign flag_Z = (result == 32'd0);

endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: expected results queued at each accepted start, checked on done.
// Checks value, address, write/illegal pulses, flags, latency and busy length per completion.
// Also covers reset values, start-while-busy, result hold and asynchronous abort.
module tb_mul_unit;

    localparam int RADIX = 2;
    localparam bit ETERM = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        accumulate;
    logic [31:0] Rm;
    logic [31:0] Rs;
    logic [31:0] Rn;
    logic [3:0]  rd_addr;
    logic        busy;
    logic        done;
    logic        write_en;
    logic [31:0] result;
    logic [3:0]  result_addr;
    logic        flag_N;
    logic        flag_Z;
    logic        illegal;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  addr;
        logic        ill;
        int          n;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   busy_len = 0;

    mul_unit #(.RADIX_BITS(RADIX), .EARLY_TERM(ETERM)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .accumulate (accumulate),
        .Rm         (Rm),
        .Rs         (Rs),
        .Rn         (Rn),
        .rd_addr    (rd_addr),
        .busy       (busy),
        .done       (done),
        .write_en   (write_en),
        .result     (result),
        .result_addr(result_addr),
        .flag_N     (flag_N),
        .flag_Z     (flag_Z),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference: plain 32-bit product plus addend; iteration count from digit-wise shifting.
    function automatic exp_t model(input logic acc, input logic [31:0] rm, input logic [31:0] rs,
                                   input logic [31:0] rn, input logic [3:0] rd);
        exp_t        e;
        logic [31:0] mp;
        e.res  = rm * rs + (acc ? rn : 32'd0);
        e.addr = rd;
        e.ill  = (rd == 4'd15);
        e.n    = 0;
        e.cyc  = 0;
        if (ETERM) begin
            mp = rs;
            while (mp != 32'd0) begin
                mp  = mp >> RADIX;
                e.n = e.n + 1;
            end
        end else begin
            e.n = 32 / RADIX;
        end
        return e;
    endfunction

    task automatic scramble();
        Rm         = $urandom;
        Rs         = $urandom;
        Rn         = $urandom;
        accumulate = 1'($urandom_range(0, 1));
        rd_addr    = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Drive one request in IDLE; operands are scrambled right after the start edge.
    task automatic issue(input logic acc, input logic [31:0] rm, input logic [31:0] rs,
                         input logic [31:0] rn, input logic [3:0] rd, input bit track);
        exp_t e;
        wait_idle();
        accumulate = acc;
        Rm         = rm;
        Rs         = rs;
        Rn         = rn;
        rd_addr    = rd;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble();
        if (track) begin
            e     = model(acc, rm, rs, rn, rd);
            e.cyc = cyc + e.n;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    // Output monitor: every done must match the oldest expected completion.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (busy) busy_len = busy_len + 1;
            else      busy_len = 0;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("result",   result, e.res);
                    chk("addr",     32'(result_addr), 32'(e.addr));
                    chk("write_en", 32'(write_en), 32'(!e.ill));
                    chk("illegal",  32'(illegal), 32'(e.ill));
                    chk("flag_N",   32'(flag_N), 32'(e.res[31]));
                    chk("flag_Z",   32'(flag_Z), 32'(e.res == 32'd0));
                    chk("latency",  32'(cyc), 32'(e.cyc));
                    chk("busy_len", 32'(busy_len), 32'(e.n + 1));
                end
            end else if (write_en || illegal) begin
                chk("stray_pulse", 32'd1, 32'd0);
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        accumulate = 1'b0;
        Rm         = 32'd0;
        Rs         = 32'd0;
        Rn         = 32'd0;
        rd_addr    = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy",     32'(busy), 32'd0);
        chk("rst_done",     32'(done), 32'd0);
        chk("rst_write_en", 32'(write_en), 32'd0);
        chk("rst_illegal",  32'(illegal), 32'd0);
        chk("rst_result",   result, 32'd0);
        chk("rst_addr",     32'(result_addr), 32'd0);
        rst_n = 1'b1;

        // Directed cases
        issue(1'b0, 32'd7, 32'd6, 32'd0, 4'd3, 1'b1);
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 4'd1, 1'b1);
        issue(1'b1, 32'd3, 32'd4, 32'hFFFF_FFF4, 4'd2, 1'b1);
        issue(1'b1, 32'h0000_1234, 32'd0, 32'd5, 4'd6, 1'b1);
        issue(1'b0, 32'd2, 32'd2, 32'd0, 4'd15, 1'b1);
        issue(1'b0, 32'h8000_0000, 32'd1, 32'd0, 4'd7, 1'b1);
        drain();

        // Result and address hold after completion
        repeat (3) @(negedge clk);
        chk("hold_result", result, 32'h8000_0000);
        chk("hold_addr",   32'(result_addr), 32'd7);
        chk("hold_flag_N", 32'(flag_N), 32'd1);

        // Start held high with changing operands during CALC and DONE
        begin : ignore_start
            exp_t e;
            int   k;
            issue(1'b0, 32'h1234_5678, 32'hFFFF_FFFF, 32'd0, 4'd8, 1'b1);
            for (k = 0; k < 100; k++) begin
                @(negedge clk);
                if (done) break;
                start = 1'b1;
                scramble();
            end
            if (!done) chk("done_timeout", 32'(done), 32'd1);
            accumulate = 1'b0;
            Rm         = 32'd9;
            Rs         = 32'd11;
            Rn         = 32'd0;
            rd_addr    = 4'd4;
            start      = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("idle_after_done", 32'(busy), 32'd0);
            @(posedge clk);
            #1;
            start = 1'b0;
            e     = model(1'b0, 32'd9, 32'd11, 32'd0, 4'd4);
            e.cyc = cyc + e.n;
            sb.push_back(e);
            scramble();
            drain();
        end

        // Random MUL/MLA mix, including r15 targets
        for (int i = 0; i < 20; i++) begin
            logic [31:0] rs_v;
            rs_v = (i % 4 == 0) ? ($urandom & 32'h0000_00FF) : $urandom;
            issue(1'($urandom_range(0, 1)), $urandom, rs_v, $urandom,
                  4'($urandom_range(0, 15)), 1'b1);
        end
        drain();

        // Asynchronous abort in the middle of CALC
        issue(1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'd0, 4'd9, 1'b0);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy",     32'(busy), 32'd0);
        chk("abort_done",     32'(done), 32'd0);
        chk("abort_write_en", 32'(write_en), 32'd0);
        chk("abort_result",   result, 32'd0);
        chk("abort_addr",     32'(result_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_resume", 32'(busy), 32'd0);
        issue(1'b0, 32'd5, 32'd5, 32'd0, 4'd5, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
